// File: rtl/radio_fp_pkg.sv
// Shared types for the radio front-end correlation path: sample/magnitude
// typedefs, the peak-detector FSM encoding and a width helper.
package radio_fp_pkg;

  localparam int CORR_WIDTH_DEF = 32;

  typedef logic signed [CORR_WIDTH_DEF-1:0] corr_t;
  typedef logic        [CORR_WIDTH_DEF-1:0] mag_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCUM  = 2'd1,
    REPORT = 2'd2
  } peak_fsm_t;

  // Bits needed to index n items; never less than one so ports stay legal.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/corr_abs_sat.sv
// Combinational saturating absolute value of a signed correlation sample.
// The most negative input maps to the largest positive value instead of wrapping.
module corr_abs_sat #(
  parameter int W = 32
) (
  input  logic signed [W-1:0] din,
  output logic        [W-1:0] mag
);

  localparam logic [W-1:0] MOST_NEG = {1'b1, {(W-1){1'b0}}};
  localparam logic [W-1:0] MAX_POS  = {1'b0, {(W-1){1'b1}}};

  logic [W-1:0] din_u;
  logic [W-1:0] neg_u;

  always_comb begin
    din_u = $unsigned(din);
    neg_u = $unsigned(-din);
    if (din_u == MOST_NEG) begin
      mag = MAX_POS;
    end else if (din[W-1]) begin
      mag = neg_u;
    end else begin
      mag = din_u;
    end
  end

endmodule

// File: rtl/correlation_peak_detector.sv
// Windowed peak search over the matched_filter correlation stream; reports the
// largest magnitude, its index and a holdoff-gated detect at every window end.
module correlation_peak_detector
  import radio_fp_pkg::*;
#(
  parameter int CORR_WIDTH      = CORR_WIDTH_DEF,
  parameter int WINDOW_LENGTH   = 1000,
  parameter int HOLDOFF_WINDOWS = 4,
  localparam int IDX_W          = idx_width(WINDOW_LENGTH)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         axiiv,
  input  logic signed [CORR_WIDTH-1:0] axiid,
  input  logic        [CORR_WIDTH-1:0] threshold,
  output logic                         axiov,
  output logic                         detect,
  output logic        [CORR_WIDTH-1:0] peak_mag,
  output logic        [IDX_W-1:0]      peak_index,
  output logic        [15:0]           window_count,
  output peak_fsm_t                    fsm_state
);

  // Stream semantics: axiiv/axiid is valid-only; every cycle with axiiv=1 is
  // a consumed sample. axiov is a one-cycle strobe with no ready; the
  // registered results stay stable until the next strobe.

  localparam int HO_W = idx_width(HOLDOFF_WINDOWS + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WINDOW_LENGTH - 1);
  localparam logic [HO_W-1:0]  HO_LOAD  = HO_W'(HOLDOFF_WINDOWS);

  peak_fsm_t state_q, state_d;

  logic [CORR_WIDTH-1:0] thr_q, thr_d;
  logic [CORR_WIDTH-1:0] run_peak_q, run_peak_d;
  logic [IDX_W-1:0]      run_idx_q, run_idx_d;
  logic [IDX_W-1:0]      sample_idx_q, sample_idx_d;
  logic [HO_W-1:0]       holdoff_q, holdoff_d;
  logic [15:0]           window_count_q, window_count_d;
  logic [CORR_WIDTH-1:0] peak_mag_q, peak_mag_d;
  logic [IDX_W-1:0]      peak_index_q, peak_index_d;
  logic                  detect_q, detect_d;

  logic [CORR_WIDTH-1:0] mag;
  logic                  start_win;
  logic                  last_smp;
  logic [CORR_WIDTH-1:0] cand_peak;
  logic [IDX_W-1:0]      cand_idx;
  logic [CORR_WIDTH-1:0] cand_thr;
  logic                  hit;

  corr_abs_sat #(
    .W (CORR_WIDTH)
  ) u_abs (
    .din (axiid),
    .mag (mag)
  );

  // A sample seen outside ACCUM always opens a new window; that is what lets
  // REPORT accept sample 0 of the next window without a bubble.
  always_comb begin
    start_win = axiiv && (state_q != ACCUM);
    if (start_win) begin
      last_smp = (WINDOW_LENGTH == 1);
    end else begin
      last_smp = axiiv && (sample_idx_q == LAST_IDX);
    end
  end

  // Peak including the current sample; strict compare keeps the earlier index on ties.
  always_comb begin
    if (start_win) begin
      cand_peak = mag;
      cand_idx  = '0;
      cand_thr  = threshold;
    end else if (mag > run_peak_q) begin
      cand_peak = mag;
      cand_idx  = sample_idx_q;
      cand_thr  = thr_q;
    end else begin
      cand_peak = run_peak_q;
      cand_idx  = run_idx_q;
      cand_thr  = thr_q;
    end
    hit = (cand_peak >= cand_thr) && (holdoff_q == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, REPORT: begin
        if (axiiv) begin
          state_d = last_smp ? REPORT : ACCUM;
        end else begin
          state_d = IDLE;
        end
      end
      ACCUM: begin
        if (axiiv && last_smp) begin
          state_d = REPORT;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Result registers load on the edge that accepts the last sample, so they
  // are already valid during the REPORT cycle.
  always_comb begin
    thr_d          = thr_q;
    run_peak_d     = run_peak_q;
    run_idx_d      = run_idx_q;
    sample_idx_d   = sample_idx_q;
    holdoff_d      = holdoff_q;
    window_count_d = window_count_q;
    peak_mag_d     = peak_mag_q;
    peak_index_d   = peak_index_q;
    detect_d       = detect_q;

    if (axiiv) begin
      thr_d        = cand_thr;
      run_peak_d   = cand_peak;
      run_idx_d    = cand_idx;
      sample_idx_d = start_win ? IDX_W'(1) : (sample_idx_q + IDX_W'(1));
    end

    if (last_smp) begin
      peak_mag_d     = cand_peak;
      peak_index_d   = cand_idx;
      detect_d       = hit;
      window_count_d = window_count_q + 16'd1;
      sample_idx_d   = '0;
      if (hit) begin
        holdoff_d = HO_LOAD;
      end else if (holdoff_q != '0) begin
        holdoff_d = holdoff_q - HO_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      thr_q          <= '0;
      run_peak_q     <= '0;
      run_idx_q      <= '0;
      sample_idx_q   <= '0;
      holdoff_q      <= '0;
      window_count_q <= '0;
      peak_mag_q     <= '0;
      peak_index_q   <= '0;
      detect_q       <= 1'b0;
    end else begin
      thr_q          <= thr_d;
      run_peak_q     <= run_peak_d;
      run_idx_q      <= run_idx_d;
      sample_idx_q   <= sample_idx_d;
      holdoff_q      <= holdoff_d;
      window_count_q <= window_count_d;
      peak_mag_q     <= peak_mag_d;
      peak_index_q   <= peak_index_d;
      detect_q       <= detect_d;
    end
  end

  always_comb begin
    axiov        = (state_q == REPORT);
    detect       = detect_q;
    peak_mag     = peak_mag_q;
    peak_index   = peak_index_q;
    window_count = window_count_q;
    fsm_state    = state_q;
  end

endmodule

// File: tb/tb_correlation_peak_detector.sv
// Bench for correlation_peak_detector with an 8-sample window and a holdoff of
// two windows; a window-level model feeds an expected-result queue.
module tb_correlation_peak_detector;
  import radio_fp_pkg::*;

  localparam int WL = 8;
  localparam int HO = 2;
  localparam int EW = 16 + 1 + 3 + 32;

  logic              clk;
  logic              rst_n;
  logic              axiiv;
  logic signed [31:0] axiid;
  logic [31:0]       threshold;
  logic              axiov;
  logic              detect;
  logic [31:0]       peak_mag;
  logic [2:0]        peak_index;
  logic [15:0]       window_count;
  peak_fsm_t         fsm_state;

  correlation_peak_detector #(
    .CORR_WIDTH      (32),
    .WINDOW_LENGTH   (WL),
    .HOLDOFF_WINDOWS (HO)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .axiiv        (axiiv),
    .axiid        (axiid),
    .threshold    (threshold),
    .axiov        (axiov),
    .detect       (detect),
    .peak_mag     (peak_mag),
    .peak_index   (peak_index),
    .window_count (window_count),
    .fsm_state    (fsm_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int step_n   = 0;

  // ---------------- scoreboard / model state ----------------
  logic [EW-1:0] exp_q[$];
  logic [31:0]   win_q[$];
  logic [31:0]   m_thr;
  int            m_ho = 0;
  int            m_wc = 0;
  logic          pending = 1'b0;

  logic          obs_axiov;
  logic          obs_det;
  logic [31:0]   obs_mag;
  logic [2:0]    obs_idx;
  logic [15:0]   obs_wc;

  // Window-level model: saturating |x|, first maximum wins, holdoff by window count.
  task automatic model_push(input logic [31:0] d);
    longint best;
    int     bi;
    logic   det;
    if (win_q.size() == 0) m_thr = threshold;
    win_q.push_back(d);
    if (win_q.size() == WL) begin
      best = -1;
      bi   = 0;
      for (int i = 0; i < WL; i++) begin
        int     s;
        longint v;
        s = int'(win_q[i]);
        v = s;
        if (v < 0) v = -v;
        if (v > 64'sd2147483647) v = 64'sd2147483647;
        if (v > best) begin
          best = v;
          bi   = i;
        end
      end
      det = (best >= longint'({32'd0, m_thr})) && (m_ho == 0);
      if (det) m_ho = HO;
      else if (m_ho > 0) m_ho = m_ho - 1;
      m_wc = (m_wc + 1) % 65536;
      exp_q.push_back({16'(m_wc), det, 3'(bi), 32'(best)});
      pending = 1'b1;
      win_q.delete();
    end
  endtask

  // ---------------- driver ----------------
  // Observes outputs of the previous cycle, scores any due strobe, then drives.
  task automatic step(input logic v, input logic [31:0] d);
    logic          due;
    logic [EW-1:0] e;
    @(negedge clk);
    obs_axiov = axiov;
    obs_det   = detect;
    obs_mag   = peak_mag;
    obs_idx   = peak_index;
    obs_wc    = window_count;
    due       = pending;
    pending   = 1'b0;
    step_n++;
    checks++;
    if (obs_axiov !== due) begin
      failures++;
      $display("FAIL strobe_timing step=%0d axiov=%b expected=%b", step_n, obs_axiov, due);
    end
    if (due) begin
      e = exp_q.pop_front();
      if (obs_axiov === 1'b1) begin
        checks++;
        if ({obs_wc, obs_det, obs_idx, obs_mag} !== e) begin
          failures++;
          $display("FAIL window_result step=%0d got wc=%0d det=%b idx=%0d mag=%h expected wc=%0d det=%b idx=%0d mag=%h",
                   step_n, obs_wc, obs_det, obs_idx, obs_mag, e[51:36], e[35], e[34:32], e[31:0]);
        end
      end
    end
    axiiv = v;
    axiid = d;
    if (v) model_push(d);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    axiiv = 1'b0;
    axiid = '0;
    win_q.delete();
    exp_q.delete();
    m_ho    = 0;
    m_wc    = 0;
    pending = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  function automatic logic [31:0] small_val(input int lim);
    int r;
    r = int'($urandom_range(0, 2 * lim)) - lim;
    return 32'(r);
  endfunction

  // ---------------- tests ----------------
  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b0;
    axiiv = 1'b0;
    #1;
    checks++;
    if ({axiov, detect, peak_mag, peak_index, window_count} !== '0) begin
      failures++;
      $display("FAIL reset_outputs got axiov=%b det=%b mag=%h idx=%0d wc=%0d expected all zero",
               axiov, detect, peak_mag, peak_index, window_count);
    end
    checks++;
    if (fsm_state !== IDLE) begin
      failures++;
      $display("FAIL reset_state got %0d expected %0d", fsm_state, IDLE);
    end
    do_reset();
  endtask

  task automatic test_basic();
    int vals[WL] = '{1, 2, 3, -90, 4, 5, 6, 7};
    threshold = 32'd50;
    for (int i = 0; i < WL; i++) step(1'b1, 32'(vals[i]));
    step(1'b0, '0);
    checks++;
    if (obs_axiov !== 1'b1 || obs_mag !== 32'd90 || obs_idx !== 3'd3 || obs_det !== 1'b1 || obs_wc !== 16'd1) begin
      failures++;
      $display("FAIL basic_window got axiov=%b mag=%0d idx=%0d det=%b wc=%0d expected 1 90 3 1 1",
               obs_axiov, obs_mag, obs_idx, obs_det, obs_wc);
    end
    step(1'b0, '0);
    checks++;
    if (obs_axiov !== 1'b0 || obs_mag !== 32'd90) begin
      failures++;
      $display("FAIL basic_hold got axiov=%b mag=%0d expected 0 90", obs_axiov, obs_mag);
    end
  endtask

  task automatic test_tie_sat();
    int pos;
    threshold = 32'd50;
    for (int i = 0; i < WL; i++) step(1'b1, (i % 2 == 0) ? 32'd10 : 32'hFFFF_FFF6);
    step(1'b0, '0);
    checks++;
    if (obs_mag !== 32'd10 || obs_idx !== 3'd0) begin
      failures++;
      $display("FAIL tie_index got mag=%0d idx=%0d expected 10 0", obs_mag, obs_idx);
    end
    pos = int'($urandom_range(1, WL - 1));
    for (int i = 0; i < WL; i++) step(1'b1, (i == pos) ? 32'h8000_0000 : small_val(1000));
    step(1'b0, '0);
    checks++;
    if (obs_mag !== 32'h7FFF_FFFF || obs_idx !== 3'(pos)) begin
      failures++;
      $display("FAIL saturation got mag=%h idx=%0d expected 7fffffff %0d", obs_mag, obs_idx, pos);
    end
  endtask

  task automatic test_holdoff();
    logic [3:0] pat;
    int         pos;
    do_reset();
    threshold = 32'd100;
    for (int w = 0; w < 4; w++) begin
      pos = int'($urandom_range(0, WL - 1));
      for (int i = 0; i < WL; i++) step(1'b1, (i == pos) ? 32'd500 : small_val(99));
      step(1'b0, '0);
      pat[w] = obs_det;
    end
    checks++;
    if (pat !== 4'b1001) begin
      failures++;
      $display("FAIL holdoff_pattern got w0..w3=%b%b%b%b expected 1001", pat[0], pat[1], pat[2], pat[3]);
    end
  endtask

  task automatic test_gaps();
    threshold = 32'($urandom_range(0, 150));
    step(1'b0, '0);
    for (int i = 0; i < WL; i++) begin
      step(1'b1, (i == 5) ? 32'd77 : small_val(76));
      step(1'b0, small_val(5000));
    end
    checks++;
    if (obs_axiov !== 1'b1 || obs_mag !== 32'd77 || obs_idx !== 3'd5) begin
      failures++;
      $display("FAIL gap_window got axiov=%b mag=%0d idx=%0d expected 1 77 5", obs_axiov, obs_mag, obs_idx);
    end
  endtask

  task automatic test_back_to_back();
    int pk[3] = '{0, 7, 4};
    int at[$];
    int ix[$];
    threshold = 32'd1500;
    for (int w = 0; w < 3; w++) begin
      for (int i = 0; i < WL; i++) begin
        step(1'b1, (i == pk[w]) ? 32'(2000 + $urandom_range(0, 500)) : small_val(1000));
        if (obs_axiov === 1'b1) begin
          at.push_back(step_n);
          ix.push_back(int'(obs_idx));
        end
      end
    end
    step(1'b0, '0);
    if (obs_axiov === 1'b1) begin
      at.push_back(step_n);
      ix.push_back(int'(obs_idx));
    end
    checks++;
    if (at.size() != 3) begin
      failures++;
      $display("FAIL b2b_strobe_count got %0d expected 3", at.size());
    end else begin
      checks++;
      if (at[1] - at[0] != WL || at[2] - at[1] != WL) begin
        failures++;
        $display("FAIL b2b_spacing got %0d,%0d expected %0d", at[1] - at[0], at[2] - at[1], WL);
      end
      checks++;
      if (ix[0] != 0 || ix[1] != 7 || ix[2] != 4) begin
        failures++;
        $display("FAIL b2b_indices got %0d,%0d,%0d expected 0,7,4", ix[0], ix[1], ix[2]);
      end
    end
  endtask

  task automatic test_reset_mid();
    int strobes;
    do_reset();
    threshold = 32'd10;
    for (int i = 0; i < 5; i++) step(1'b1, 32'(5000 + i));
    do_reset();
    strobes = 0;
    for (int i = 0; i < WL; i++) begin
      step(1'b1, (i == 2) ? 32'd3000 : small_val(2000));
      if (obs_axiov === 1'b1) strobes++;
    end
    step(1'b0, '0);
    if (obs_axiov === 1'b1) strobes++;
    checks++;
    if (strobes != 1 || obs_wc !== 16'd1 || obs_mag !== 32'd3000 || obs_idx !== 3'd2) begin
      failures++;
      $display("FAIL reset_mid got strobes=%0d wc=%0d mag=%0d idx=%0d expected 1 1 3000 2",
               strobes, obs_wc, obs_mag, obs_idx);
    end
  endtask

  task automatic test_random();
    logic [31:0] d;
    for (int n = 0; n < 200; n++) begin
      if ($urandom_range(0, 9) == 0) threshold = 32'($urandom_range(0, 4000));
      d = ($urandom_range(0, 5) == 0) ? 32'($urandom()) : small_val(4000);
      if ($urandom_range(0, 30) == 0) d = 32'h8000_0000;
      step($urandom_range(0, 3) != 0, d);
    end
    repeat (3) step(1'b0, '0);
    checks++;
    if (exp_q.size() != 0 || pending) begin
      failures++;
      $display("FAIL drain got %0d outstanding results expected 0", exp_q.size());
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    axiiv     = 1'b0;
    axiid     = '0;
    threshold = '0;
    test_reset();
    test_basic();
    test_tie_sat();
    test_holdoff();
    test_gaps();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
